// File: rtl/alarm_entry_pkg.sv
// Shared types for the alarm time-entry front end: FSM states, BCD time buffer, digit limits
// and the per-digit BCD increment rule.
package alarm_entry_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EDIT_TIME  = 2'd1,
        EDIT_ALARM = 2'd2,
        COMMIT     = 2'd3
    } state_t;

    localparam logic [1:0] DIG_HOUR1 = 2'd0;
    localparam logic [1:0] DIG_HOUR0 = 2'd1;
    localparam logic [1:0] DIG_MIN1  = 2'd2;
    localparam logic [1:0] DIG_MIN0  = 2'd3;

    localparam logic [1:0] HOUR1_MAX    = 2'd2;
    localparam logic [3:0] HOUR0_MAX    = 4'd9;
    localparam logic [3:0] HOUR0_MAX_20 = 4'd3;
    localparam logic [3:0] MIN1_MAX     = 4'd5;
    localparam logic [3:0] MIN0_MAX     = 4'd9;

    typedef struct packed {
        logic [1:0] hour1;
        logic [3:0] hour0;
        logic [3:0] min1;
        logic [3:0] min0;
    } bcd_time_t;

    // Increment one digit with wrap; keeps the value inside 00:00..23:59, no carry between digits.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t, input logic [1:0] digit);
        bcd_time_t r;
        r = t;
        case (digit)
            DIG_HOUR1: begin
                r.hour1 = (t.hour1 >= HOUR1_MAX) ? 2'd0 : t.hour1 + 2'd1;
                if (r.hour1 == HOUR1_MAX && t.hour0 > HOUR0_MAX_20) r.hour0 = HOUR0_MAX_20;
            end
            DIG_HOUR0: begin
                if (t.hour1 == HOUR1_MAX)
                    r.hour0 = (t.hour0 >= HOUR0_MAX_20) ? 4'd0 : t.hour0 + 4'd1;
                else
                    r.hour0 = (t.hour0 >= HOUR0_MAX) ? 4'd0 : t.hour0 + 4'd1;
            end
            DIG_MIN1: r.min1 = (t.min1 >= MIN1_MAX) ? 4'd0 : t.min1 + 4'd1;
            default:  r.min0 = (t.min0 >= MIN0_MAX) ? 4'd0 : t.min0 + 4'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alarm_time_entry_if.sv
// Setting interface between the time-entry front end (master) and the Alarm clock (slave).
interface alarm_time_entry_if;
    logic [1:0] hour_in1;
    logic [3:0] hour_in0;
    logic [3:0] min_in1;
    logic [3:0] min_in0;
    logic       time_set;
    logic       alarm_set;
    logic       alarm_on;
    logic [1:0] cur_hour1;
    logic [3:0] cur_hour0;
    logic [3:0] cur_min1;
    logic [3:0] cur_min0;

    modport master (
        output hour_in1, hour_in0, min_in1, min_in0, time_set, alarm_set, alarm_on,
        input  cur_hour1, cur_hour0, cur_min1, cur_min0
    );

    modport slave (
        input  hour_in1, hour_in0, min_in1, min_in0, time_set, alarm_set, alarm_on,
        output cur_hour1, cur_hour0, cur_min1, cur_min0
    );
endinterface

// File: rtl/alarm_time_entry_btn_edge.sv
// Rising-edge detector for one debounced button level; history tracks the button during reset
// so a button held through reset produces no edge on release of reset.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise_c
);
    logic btn_q;

    always_ff @(posedge clk) begin
        btn_q <= btn;
    end

    assign rise_c = btn & ~btn_q & ~reset;
endmodule

// File: rtl/alarm_time_entry.sv
// Button-driven HH:MM editor feeding the Alarm clock's time/alarm setting interface.
module alarm_time_entry
    import alarm_entry_pkg::*;
#(
    parameter int unsigned SET_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_mode,
    input  logic                      btn_next,
    input  logic                      btn_inc,
    input  logic                      btn_enter,
    input  logic                      btn_arm,
    alarm_time_entry_if.master        alarm,
    output logic                      editing,
    output logic [1:0]                edit_digit
);
    localparam int unsigned CNT_W = (SET_HOLD > 1) ? $clog2(SET_HOLD) : 1;

    logic mode_rise, next_rise, inc_rise, enter_rise, arm_rise;

    btn_edge u_mode  (.clk(clk), .reset(reset), .btn(btn_mode),  .rise_c(mode_rise));
    btn_edge u_next  (.clk(clk), .reset(reset), .btn(btn_next),  .rise_c(next_rise));
    btn_edge u_inc   (.clk(clk), .reset(reset), .btn(btn_inc),   .rise_c(inc_rise));
    btn_edge u_enter (.clk(clk), .reset(reset), .btn(btn_enter), .rise_c(enter_rise));
    btn_edge u_arm   (.clk(clk), .reset(reset), .btn(btn_arm),   .rise_c(arm_rise));

    state_t           state;
    bcd_time_t        edit_buf;
    bcd_time_t        shadow_alarm;
    logic [CNT_W-1:0] hold_cnt;
    logic             time_set_q;
    logic             alarm_set_q;
    logic             alarm_on_q;

    // Edit FSM; within EDIT_* the priority is enter > mode > next > inc.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            edit_buf     <= '0;
            shadow_alarm <= '0;
            edit_digit   <= DIG_HOUR1;
            hold_cnt     <= '0;
            time_set_q   <= 1'b0;
            alarm_set_q  <= 1'b0;
            alarm_on_q   <= 1'b0;
            editing      <= 1'b0;
        end else begin
            if (arm_rise) alarm_on_q <= ~alarm_on_q;
            case (state)
                IDLE: begin
                    if (mode_rise) begin
                        state      <= EDIT_TIME;
                        editing    <= 1'b1;
                        edit_buf   <= {alarm.cur_hour1, alarm.cur_hour0, alarm.cur_min1, alarm.cur_min0};
                        edit_digit <= DIG_HOUR1;
                    end
                end
                EDIT_TIME, EDIT_ALARM: begin
                    if (enter_rise) begin
                        state    <= COMMIT;
                        editing  <= 1'b0;
                        hold_cnt <= CNT_W'(SET_HOLD - 1);
                        if (state == EDIT_ALARM) begin
                            alarm_set_q  <= 1'b1;
                            shadow_alarm <= edit_buf;
                        end else begin
                            time_set_q <= 1'b1;
                        end
                    end else if (mode_rise) begin
                        if (state == EDIT_TIME) begin
                            state      <= EDIT_ALARM;
                            edit_buf   <= shadow_alarm;
                            edit_digit <= DIG_HOUR1;
                        end else begin
                            state   <= IDLE;
                            editing <= 1'b0;
                        end
                    end else if (next_rise) begin
                        edit_digit <= edit_digit + 2'd1;
                    end else if (inc_rise) begin
                        edit_buf <= bcd_inc(edit_buf, edit_digit);
                    end
                end
                COMMIT: begin
                    if (hold_cnt == '0) begin
                        state       <= IDLE;
                        time_set_q  <= 1'b0;
                        alarm_set_q <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alarm.hour_in1  = edit_buf.hour1;
    assign alarm.hour_in0  = edit_buf.hour0;
    assign alarm.min_in1   = edit_buf.min1;
    assign alarm.min_in0   = edit_buf.min0;
    assign alarm.time_set  = time_set_q;
    assign alarm.alarm_set = alarm_set_q;
    assign alarm.alarm_on  = alarm_on_q;
endmodule

// File: tb/tb_alarm_time_entry.sv
// Scoreboard bench for alarm_time_entry: each commit pushes its expected strobe kind, value and
// length; a negedge monitor pops and checks every strobe burst the DUT produces.
module tb_alarm_time_entry;

    logic clk = 1'b0;
    logic reset;
    logic btn_mode, btn_next, btn_inc, btn_enter, btn_arm;
    logic editing;
    logic [1:0] edit_digit;

    alarm_time_entry_if bus();

    alarm_time_entry #(.SET_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .btn_enter(btn_enter), .btn_arm(btn_arm),
        .alarm(bus), .editing(editing), .edit_digit(edit_digit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_alarm;
        logic [15:0] val;
        int          len;
    } exp_t;

    exp_t sb[$];
    exp_t cur_e;
    int   run_len = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bufv();
        return {2'b00, bus.hour_in1, bus.hour_in0, bus.min_in1, bus.min_in0};
    endfunction

    // Strobe monitor: kind and value on every strobe cycle, burst length when it drops.
    always @(negedge clk) begin
        if (bus.time_set | bus.alarm_set) begin
            if (run_len == 0) begin
                if (sb.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
                else cur_e = sb.pop_front();
            end
            run_len++;
            check("strobe_excl", 32'(bus.time_set & bus.alarm_set), 32'd0);
            check("strobe_kind", 32'(bus.alarm_set), 32'(cur_e.is_alarm));
            check("strobe_val", 32'(bufv()), 32'(cur_e.val));
        end else if (run_len != 0) begin
            check("strobe_len", 32'(run_len), 32'(cur_e.len));
            run_len = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_mode  = v;
            1: btn_next  = v;
            2: btn_inc   = v;
            3: btn_enter = v;
            default: btn_arm = v;
        endcase
    endtask

    task automatic press(input int b, input int times);
        for (int i = 0; i < times; i++) begin
            set_btn(b, 1'b1);
            cyc(1);
            set_btn(b, 1'b0);
            cyc(1);
        end
    endtask

    task automatic set_cur(input logic [15:0] t);
        bus.cur_hour1 = t[13:12];
        bus.cur_hour0 = t[11:8];
        bus.cur_min1  = t[7:4];
        bus.cur_min0  = t[3:0];
    endtask

    task automatic push(input logic is_alarm, input logic [15:0] val, input int len);
        exp_t e;
        e.is_alarm = is_alarm;
        e.val      = val;
        e.len      = len;
        sb.push_back(e);
    endtask

    localparam int B_MODE = 0, B_NEXT = 1, B_INC = 2, B_ENTER = 3, B_ARM = 4;

    initial begin
        // Reset with every button held high.
        reset = 1'b1;
        btn_mode = 1'b1; btn_next = 1'b1; btn_inc = 1'b1; btn_enter = 1'b1; btn_arm = 1'b1;
        set_cur(16'h1722);
        cyc(3);
        check("rst_buf", 32'(bufv()), 32'h0000);
        check("rst_editing", 32'(editing), 32'd0);
        check("rst_digit", 32'(edit_digit), 32'd0);
        check("rst_alarm_on", 32'(bus.alarm_on), 32'd0);
        check("rst_time_set", 32'(bus.time_set), 32'd0);
        reset = 1'b0;
        cyc(3);
        check("held_no_edit", 32'(editing), 32'd0);
        check("held_no_arm", 32'(bus.alarm_on), 32'd0);
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_enter = 1'b0; btn_arm = 1'b0;
        cyc(2);
        check("release_idle", 32'(editing), 32'd0);

        // Time edit: 17:22, min1 +5 wraps 5->0 -> 17:12.
        press(B_MODE, 1);
        check("et_editing", 32'(editing), 32'd1);
        check("et_preload", 32'(bufv()), 32'h1722);
        press(B_NEXT, 2);
        check("et_digit", 32'(edit_digit), 32'd2);
        press(B_INC, 5);
        check("et_buf", 32'(bufv()), 32'h1712);
        push(1'b0, 16'h1712, 4);
        press(B_ENTER, 1);
        cyc(5);
        check("et_done_idle", 32'(editing), 32'd0);
        check("et_strobe_low", 32'(bus.time_set), 32'd0);

        // Alarm edit to 21:45, then re-entry preloads it.
        press(B_MODE, 2);
        check("ea_editing", 32'(editing), 32'd1);
        check("ea_preload0", 32'(bufv()), 32'h0000);
        press(B_INC, 2);
        press(B_NEXT, 1); press(B_INC, 1);
        press(B_NEXT, 1); press(B_INC, 4);
        press(B_NEXT, 1); press(B_INC, 5);
        check("ea_buf", 32'(bufv()), 32'h2145);
        push(1'b1, 16'h2145, 4);
        press(B_ENTER, 1);
        cyc(5);
        press(B_MODE, 2);
        check("ea_shadow", 32'(bufv()), 32'h2145);
        press(B_MODE, 1);
        check("ea_abort_idle", 32'(editing), 32'd0);
        check("ea_abort_buf", 32'(bufv()), 32'h2145);

        // Hour clamp: 19:00 -> 23:00, then hour0 3 -> 0.
        set_cur(16'h1900);
        press(B_MODE, 1);
        press(B_INC, 1);
        check("clamp_h1", 32'(bufv()), 32'h2300);
        press(B_NEXT, 1);
        press(B_INC, 1);
        check("wrap_h0_20", 32'(bufv()), 32'h2000);
        press(B_MODE, 2);
        check("clamp_exit", 32'(editing), 32'd0);

        // enter+inc same cycle: commit only; arm and mode during COMMIT.
        set_cur(16'h1234);
        press(B_MODE, 1);
        press(B_NEXT, 1);
        push(1'b0, 16'h1234, 4);
        btn_enter = 1'b1; btn_inc = 1'b1;
        cyc(1);
        btn_enter = 1'b0; btn_inc = 1'b0;
        check("prio_digit", 32'(edit_digit), 32'd1);
        check("prio_buf", 32'(bufv()), 32'h1234);
        cyc(1);
        btn_arm = 1'b1;
        cyc(1);
        btn_arm = 1'b0;
        check("arm_in_commit", 32'(bus.alarm_on), 32'd1);
        btn_mode = 1'b1;
        cyc(1);
        btn_mode = 1'b0;
        cyc(4);
        check("mode_ignored", 32'(editing), 32'd0);

        // Reset on the second strobe cycle.
        set_cur(16'h0815);
        press(B_MODE, 1);
        push(1'b0, 16'h0815, 2);
        btn_enter = 1'b1;
        cyc(1);
        btn_enter = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        check("rst_mid_strobe", 32'(bus.time_set), 32'd0);
        check("rst_mid_editing", 32'(editing), 32'd0);
        check("rst_mid_buf", 32'(bufv()), 32'h0000);
        check("rst_mid_alarm_on", 32'(bus.alarm_on), 32'd0);
        reset = 1'b0;
        cyc(3);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
